// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STREAK_MAX_DEF = 4;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between fetch and data requests: data first, fetch once a streak is used up.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is actually taken.
module arb_pick #(
  parameter int STREAK_MAX = 4,
  parameter int STREAK_W   = $clog2(STREAK_MAX + 1)
) (
  input  logic                i_f_req,
  input  logic                i_d_req,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_pick_f,
  output logic                o_pick_d
);

  logic w_fetch_due;

  // A waiting fetch overrides data only after it has sat through a full streak of data grants.
  always_comb begin
    w_fetch_due = i_f_req && (i_streak >= STREAK_W'(STREAK_MAX));
    o_pick_d    = i_d_req && !w_fetch_due;
    o_pick_f    = i_f_req && !o_pick_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one outstanding access at a time.
// Latency: gnt in cycle 0, m_req from cycle 1, rvalid in the m_rvalid cycle (3 cycles minimum).
// Backpressure: requesters hold req until gnt; m_req is held stable until m_gnt; no timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch requester
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // data requester
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // shared memory port
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(STREAK_MAX + 1);

  state_e              r_state;
  owner_e              r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [STREAK_W-1:0] r_streak;

  logic w_pick_i;
  logic w_pick_d;
  logic w_idle;
  logic w_resp_done;

  arb_pick #(
    .STREAK_MAX (STREAK_MAX),
    .STREAK_W   (STREAK_W)
  ) u_pick (
    .i_f_req  (i_req),
    .i_d_req  (d_req),
    .i_streak (r_streak),
    .o_pick_f (w_pick_i),
    .o_pick_d (w_pick_d)
  );

  // Grants and response routing; both are suppressed while reset is held so a
  // dropped access can never leak an rvalid and no grant is given that would be lost.
  always_comb begin
    w_idle      = (r_state == IDLE) && !reset;
    w_resp_done = (r_state == RESP) && m_rvalid && !reset;
    i_gnt       = w_idle && w_pick_i;
    d_gnt       = w_idle && w_pick_d;
    i_rvalid    = w_resp_done && (r_owner == OWN_I);
    d_rvalid    = w_resp_done && (r_owner == OWN_D);
    i_rdata     = i_rvalid ? m_rdata : '0;
    d_rdata     = d_rvalid ? m_rdata : '0;
    m_req       = (r_state == REQ);
    m_we        = r_we;
    m_addr      = r_addr;
    m_wdata     = r_wdata;
    m_be        = r_be;
  end

  // Transaction FSM: capture the winner in IDLE, present it in REQ, wait for its response in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_owner  <= OWN_I;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_streak <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // The streak only counts data grants that a waiting fetch had to sit through.
          if (!i_req || w_pick_i) begin
            r_streak <= '0;
          end else if (w_pick_d && (r_streak < STREAK_W'(STREAK_MAX))) begin
            r_streak <= r_streak + STREAK_W'(1);
          end
          if (w_pick_d) begin
            r_owner <= OWN_D;
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_be    <= d_be;
            r_state <= REQ;
          end else if (w_pick_i) begin
            r_owner <= OWN_I;
            r_we    <= 1'b0;
            r_addr  <= i_addr;
            r_wdata <= '0;
            r_be    <= '1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (m_gnt) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          if (m_rvalid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified memory port between the instruction-fetch requester and the data-access requester (the memory handler side of the CPU). It sits between the pipeline/memory handler and a single-ported memory. It serialises their transactions with one outstanding access at a time and routes each response back to its owner. Data requests have priority, and a bounded-streak rule keeps instruction fetch from starving.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STREAK_MAX, 4, maximum consecutive data grants while a fetch waits (≥1)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store acknowledge
- d_rdata  out  DATA_W  load data
- m_req, m_we, m_addr, m_wdata, m_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory request
- m_gnt  in  1  memory accepted the request
- m_rvalid  in  1  memory response valid; exactly one per accepted request
- m_rdata  in  DATA_W  memory read data

## Operation
- The FSM has three states.
  - IDLE: choose an owner.
    - d_req wins, unless i_req is high and streak == STREAK_MAX, in which case fetch wins.
    - On a choice, pulse the winner's gnt (combinational, same cycle), register the owner and the request fields, and go to REQ.
    - If there is no request, stay in IDLE.
  - REQ: m_req = 1 with the registered fields, held stable until m_gnt. On m_gnt, go to RESP.
  - RESP: wait for m_rvalid. In the m_rvalid cycle, drive the owner's rvalid = 1 and rdata = m_rdata, then go to IDLE.
- Fetch transactions drive m_we = 0 and m_be = all ones.
- The non-owner's rvalid is 0. Unselected rdata outputs are 0.
- Streak counter (width $clog2(STREAK_MAX+1)):
  - Increments on each data grant made while i_req = 1, saturating at STREAK_MAX.
  - Clears on a fetch grant, and on any IDLE cycle where i_req = 0.
- Writes also complete through RESP. d_rvalid acknowledges a store, and d_rdata is don't-care for stores.
- Request inputs are sampled only in IDLE. Changes to them in REQ or RESP are ignored.

## Timing
- Reset values: state = IDLE, streak = 0, m_req = 0, every gnt and rvalid output = 0, registered fields = 0.
- Minimum transaction with m_gnt in the first REQ cycle and m_rvalid in the first RESP cycle:
  - cycle 0: gnt
  - cycle 1: m_req
  - cycle 2: rvalid
  - cycle 3: next gnt
  - Throughput is one transaction per 3 cycles.
- Latency stretches by one cycle for each cycle m_gnt or m_rvalid is withheld. There is no timeout.
- Simultaneous i_req and d_req in IDLE: the priority rule above decides. The loser keeps its req high and is not granted.
- m_rvalid arriving outside RESP is a protocol violation. The arbiter ignores it and routes nothing.
- A reset asserted mid-transaction returns the FSM to IDLE on the next edge. Any pending response is dropped, and no rvalid is issued for it. The memory is reset on the same reset.

## Structure
- Shared package mem_arb_pkg holds:
  - owner_e {OWN_I, OWN_D}
  - state_e {IDLE, REQ, RESP}
  - default width constants
- Natural sub-module: arb_pick, the combinational winner selection from i_req, d_req and streak, so the priority rule is testable in isolation.
- Everything else is a single FSM with its registers in mem_port_arbiter.

## Test plan
- Single fetch: i_req with i_addr = 0x100. Memory grants immediately and returns 0xDEADBEEF one cycle later. Required: i_gnt in cycle 0, m_req/m_addr = 0x100 in cycle 1, i_rvalid with 0xDEADBEEF in cycle 2, d_rvalid = 0 throughout.
- Conflict: i_req and d_req rise in the same cycle, with d_we = 1, d_addr = 0x200, d_be = 0b0011. Required: d_gnt first, m_we = 1, m_be = 0b0011, then after d_rvalid the fetch is granted.
- Starvation guard with STREAK_MAX = 4: d_req held continuously and i_req held continuously. Required: 4 data grants, then 1 fetch grant, then data grants again.
- Stalled memory: m_gnt withheld for 5 cycles, then m_rvalid withheld for 3 cycles. Required: m_req and m_addr stable for all 5 cycles, no new gnt issued, and exactly one rvalid to the owner.
- Reset mid-RESP: assert reset while waiting for m_rvalid. Required: all outputs 0 on the next cycle, no rvalid issued for the dropped access, and a new i_req is granted normally after reset releases.
